sample_sequencer: RTL and testbench
===================================

// Module: sample_sequencer
// PURPOSE
//  Parametrised successor to the single-channel sample path. Scans NUM_CHANNELS pin/ADC channels at a programmed rate
//  over the shared output_sample/channel_select/sample_data bus and buffers tagged samples in an internal FIFO.
//  Configured from the scheduler cmd bus. Drained by the EBI read path. Reports overflow and scan overrun.
// PARAMETERS
//  NUM_CHANNELS  16   channels scanned, 1..32 (mask width)
//  CH_BASE       0    channel_select value of channel index 0
//  DATA_W        32   sample_data width
//  DEPTH         64   FIFO entries, power of 2, >=4
//  CFG_BASE      19'h300  cmd bus base address of config registers
// PORTS
//  clk            in   1          system clock (sys_clk domain)
//  rst            in   1          asynchronous reset, active-low
//  cmd_en         in   1          cmd bus strobe
//  cmd_wr         in   1          cmd bus write
//  cmd_addr       in   19         cmd bus address
//  cmd_data       in   32         cmd bus write data
//  current_time   in   32         global clock
//  output_sample  out  1          request: selected channel drives sample_data next cycle
//  channel_select out  8          channel being sampled
//  sample_data    in   DATA_W     sample returned by selected channel
//  rd_en          in   1          pop one entry (EBI)
//  rd_data        out  ENTRY_W    head entry {[ts32], ch8, data}; ENTRY_W = 8+DATA_W (+32 if TIMESTAMP_EN)
//  empty          out  1          FIFO empty
//  level          out  log2(DEPTH)+1  FIFO occupancy
//  overflow_cnt   out  16         samples dropped while full, saturating
//  overrun        out  1          sticky: tick arrived mid-scan
// BEHAVIOUR
//  Reset (rst=0, async): all outputs 0 except empty=1; FSM IDLE; regs cleared (run=0, mask=0, div=0).
//  Registers, written when cmd_en&cmd_wr&cmd_addr==CFG_BASE+n: n=0 CTRL {bit1 clear (self-clearing), bit0 run};
//   n=1 MASK[NUM_CHANNELS-1:0]; n=2 DIV[31:0]. Other addresses ignored.
//  Tick counter: while run=1 counts 0..DIV then wraps; tick pulses on wrap (period DIV+1 clk). run 0->1 restarts counter at 0, first tick after DIV+1 cycles.
//  FSM: IDLE -> (tick & mask!=0) SELECT; SELECT: output_sample=1, channel_select=CH_BASE+idx, for 1 clk -> CAPTURE;
//   CAPTURE: latch sample_data (+current_time at SELECT cycle) and push -> next enabled idx exists ? SELECT : IDLE.
//  Scan order ascending idx over set mask bits; 2 clk per channel. mask==0: stays IDLE, ticks ignored.
//  Tick while not IDLE: overrun<=1, tick discarded (scan continues).
//  MASK/DIV writes mid-scan take effect at next scan start; run<=0 mid-scan: current CAPTURE completes, then IDLE.
//  Push when full and no rd_en: sample dropped, overflow_cnt+1 (saturate 16'hFFFF). Push+rd_en when full: both happen.
//  rd_en when empty: ignored. rd_data is registered head (FWFT), valid when !empty; pop latency 1 clk.
//  clear: flush FIFO, zero overflow_cnt/overrun, abort scan to IDLE same cycle; run bit unaffected.
// CONFIGURATION
//  `TIMESTAMP_EN defined: entry carries 32-bit current_time sampled in SELECT cycle, at MSBs of rd_data.
//  Not defined: no timestamp storage, ENTRY_W = 8+DATA_W, current_time unused.
// STRUCTURE
//  mecobo_defs.vh (shared include): register offsets CTRL/MASK/DIV, CTRL bit positions, FSM state encodings.
//  Sub-module sample_fifo_sync: single-clock FWFT FIFO (WIDTH, DEPTH), full/empty/level, simultaneous push/pop.
//  Top holds cfg regs, tick counter, scan FSM, priority encoder for next enabled channel, counters.
// TESTING
//  1 mask=0x0005, DIV=9, run -> every 10 clk: SELECT ch0, CAPTURE, SELECT ch2, CAPTURE; 2 entries/tick, ch 0 then 2.
//  2 DEPTH=64, no reads, mask=0x1, 70 ticks -> level=64, overflow_cnt=6, first 64 samples retained in order.
//  3 mask=0xFFFF, DIV=10 (scan 32 clk > 11) -> overrun=1 after 2nd tick, no scan restarts mid-scan.
//  4 full FIFO, rd_en coincident with push -> level stays 64, overflow_cnt unchanged, head advances.
//  5 rst low mid-CAPTURE -> output_sample=0, empty=1, level=0 immediately; CTRL write clear=1 likewise zeroes counters.
//  6 `TIMESTAMP_EN: rd_data[ENTRY_W-1 -: 32] equals current_time of SELECT cycle; without: width 40 for DATA_W=32.

Source files
------------

// File: rtl/sample_sequencer_pkg.sv
// Shared definitions for the sample sequencer: register offsets, CTRL bits, scan states.
// Entry layout depends on `TIMESTAMP_EN (adds a 32-bit timestamp at the MSBs).
package sample_sequencer_pkg;

    localparam logic [18:0] CTRL_OFS = 19'd0;
    localparam logic [18:0] MASK_OFS = 19'd1;
    localparam logic [18:0] DIV_OFS  = 19'd2;

    localparam int CTRL_RUN_BIT   = 0;
    localparam int CTRL_CLEAR_BIT = 1;

`ifdef TIMESTAMP_EN
    localparam int TS_W = 32;
`else
    localparam int TS_W = 0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SELECT,
        ST_CAPTURE
    } state_t;

    // Lowest set mask bit at or above 'from'; bit 5 of the result flags "none left".
    function automatic logic [5:0] next_idx(input logic [31:0] mask, input logic [5:0] from);
        logic [5:0] result;
        result = 6'd32;
        for (int i = 31; i >= 0; i--) begin
            if (mask[i] && (6'(i) >= from)) begin
                result = 6'(i);
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/sample_sequencer_if.sv
// Bus bundle of the sample sequencer: cmd config bus, channel sample bus and FIFO read side.
// The sequencer is the slave; the surrounding system (or bench) is the master.
interface sample_sequencer_if #(
    parameter int DATA_W  = 32,
    parameter int ENTRY_W = 40,
    parameter int LEVEL_W = 7
);
    logic               cmd_en;
    logic               cmd_wr;
    logic [18:0]        cmd_addr;
    logic [31:0]        cmd_data;
    logic [31:0]        current_time;
    logic               output_sample;
    logic [7:0]         channel_select;
    logic [DATA_W-1:0]  sample_data;
    logic               rd_en;
    logic [ENTRY_W-1:0] rd_data;
    logic               empty;
    logic [LEVEL_W-1:0] level;
    logic [15:0]        overflow_cnt;
    logic               overrun;

    modport slave (
        input  cmd_en, cmd_wr, cmd_addr, cmd_data, current_time, sample_data, rd_en,
        output output_sample, channel_select, rd_data, empty, level, overflow_cnt, overrun
    );

    modport master (
        output cmd_en, cmd_wr, cmd_addr, cmd_data, current_time, sample_data, rd_en,
        input  output_sample, channel_select, rd_data, empty, level, overflow_cnt, overrun
    );
endinterface

// File: rtl/sample_sequencer_fifo.sv
// sample_fifo_sync: single-clock first-word-fall-through FIFO with flush and simultaneous push/pop.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sample_fifo_sync #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_empty,
    output logic                       o_full,
    output logic [$clog2(DEPTH):0]     o_level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_level   = r_wr_ptr - r_rd_ptr;
    assign o_empty   = (o_level == '0);
    assign o_full    = (o_level == (AW + 1)'(DEPTH));
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end
endmodule

// File: rtl/sample_sequencer.sv
// sample_sequencer: rate-driven scan of masked channels into a tagged-sample FIFO.
// Define TIMESTAMP_EN to tag each entry with current_time of its SELECT cycle.
module sample_sequencer
    import sample_sequencer_pkg::*;
#(
    parameter int          NUM_CHANNELS = 16,
    parameter int          CH_BASE      = 0,
    parameter int          DATA_W       = 32,
    parameter int          DEPTH        = 64,
    parameter logic [18:0] CFG_BASE     = 19'h300
) (
    input  logic              clk,
    input  logic              rst_n,
    sample_sequencer_if.slave bus
);
    localparam int         ENTRY_W  = TS_W + 8 + DATA_W;
    localparam int         LEVEL_W  = $clog2(DEPTH) + 1;
    localparam logic [7:0] CH_BASE8 = 8'(CH_BASE);

    state_t                  r_state;
    logic                    r_run;
    logic [NUM_CHANNELS-1:0] r_mask;
    logic [31:0]             r_div;
    logic [31:0]             r_div_act;
    logic [31:0]             r_cnt;
    logic [31:0]             r_scan_mask;
    logic [4:0]              r_idx;
    logic                    r_output_sample;
    logic [7:0]              r_channel_select;
    logic                    r_overrun;
    logic [15:0]             r_overflow_cnt;

    logic               w_wr_ctrl, w_wr_mask, w_wr_div, w_clear, w_tick, w_push;
    logic               w_full, w_empty;
    logic [31:0]        w_mask32;
    logic [5:0]         w_first, w_next;
    logic [ENTRY_W-1:0] w_entry;
    logic [LEVEL_W-1:0] w_level;

    assign w_wr_ctrl = bus.cmd_en && bus.cmd_wr && (bus.cmd_addr == CFG_BASE + CTRL_OFS);
    assign w_wr_mask = bus.cmd_en && bus.cmd_wr && (bus.cmd_addr == CFG_BASE + MASK_OFS);
    assign w_wr_div  = bus.cmd_en && bus.cmd_wr && (bus.cmd_addr == CFG_BASE + DIV_OFS);
    assign w_clear   = w_wr_ctrl && bus.cmd_data[CTRL_CLEAR_BIT];
    assign w_tick    = r_run && (r_cnt == r_div_act);
    assign w_push    = (r_state == ST_CAPTURE) && !w_clear;

    always_comb begin
        w_mask32 = '0;
        w_mask32[NUM_CHANNELS-1:0] = r_mask;
    end

    assign w_first = next_idx(w_mask32, 6'd0);
    assign w_next  = next_idx(r_scan_mask, {1'b0, r_idx} + 6'd1);

`ifdef TIMESTAMP_EN
    logic [31:0] r_ts;
    assign w_entry = {r_ts, r_channel_select, bus.sample_data};
`else
    logic w_unused_time;
    assign w_unused_time = ^bus.current_time;
    assign w_entry = {r_channel_select, bus.sample_data};
`endif

    // A clear write only flushes; it leaves the run bit as it was.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run  <= 1'b0;
            r_mask <= '0;
            r_div  <= '0;
        end else begin
            if (w_wr_ctrl && !bus.cmd_data[CTRL_CLEAR_BIT]) r_run <= bus.cmd_data[CTRL_RUN_BIT];
            if (w_wr_mask) r_mask <= bus.cmd_data[NUM_CHANNELS-1:0];
            if (w_wr_div)  r_div  <= bus.cmd_data;
        end
    end

    // The divider in use only follows DIV between scans.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_div_act <= '0;
        end else begin
            if (r_state == ST_IDLE) r_div_act <= r_div;
            if (!r_run || w_tick) r_cnt <= '0;
            else                  r_cnt <= r_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= ST_IDLE;
            r_scan_mask      <= '0;
            r_idx            <= '0;
            r_output_sample  <= 1'b0;
            r_channel_select <= '0;
            r_overrun        <= 1'b0;
`ifdef TIMESTAMP_EN
            r_ts             <= '0;
`endif
        end else if (w_clear) begin
            r_state         <= ST_IDLE;
            r_output_sample <= 1'b0;
            r_overrun       <= 1'b0;
        end else begin
            if (w_tick && (r_state != ST_IDLE)) r_overrun <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (w_tick && !w_first[5]) begin
                        r_state          <= ST_SELECT;
                        r_scan_mask      <= w_mask32;
                        r_idx            <= w_first[4:0];
                        r_output_sample  <= 1'b1;
                        r_channel_select <= CH_BASE8 + {3'b000, w_first[4:0]};
                    end
                end
                ST_SELECT: begin
                    r_state         <= ST_CAPTURE;
                    r_output_sample <= 1'b0;
`ifdef TIMESTAMP_EN
                    r_ts            <= bus.current_time;
`endif
                end
                ST_CAPTURE: begin
                    if (r_run && !w_next[5]) begin
                        r_state          <= ST_SELECT;
                        r_idx            <= w_next[4:0];
                        r_output_sample  <= 1'b1;
                        r_channel_select <= CH_BASE8 + {3'b000, w_next[4:0]};
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow_cnt <= '0;
        end else if (w_clear) begin
            r_overflow_cnt <= '0;
        end else if (w_push && w_full && !bus.rd_en && (r_overflow_cnt != 16'hFFFF)) begin
            r_overflow_cnt <= r_overflow_cnt + 16'd1;
        end
    end

    sample_fifo_sync #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (w_clear),
        .i_push  (w_push),
        .i_data  (w_entry),
        .i_pop   (bus.rd_en),
        .o_data  (bus.rd_data),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_level (w_level)
    );

    assign bus.output_sample  = r_output_sample;
    assign bus.channel_select = r_channel_select;
    assign bus.empty          = w_empty;
    assign bus.level          = w_level;
    assign bus.overflow_cnt   = r_overflow_cnt;
    assign bus.overrun        = r_overrun;
endmodule

// File: tb/tb_sample_sequencer.sv
// Directed bench for sample_sequencer: scan timing, FIFO overflow, full push+pop, overrun, clear, reset.
// Channels answer with {16'hDA7A, channel_select, running sample number}.
module tb_sample_sequencer;
`ifdef TIMESTAMP_EN
    localparam int EW = 72;
`else
    localparam int EW = 40;
`endif
    localparam logic [18:0] CTRL = 19'd0;
    localparam logic [18:0] MASK = 19'd1;
    localparam logic [18:0] DIV  = 19'd2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] timeNow = '0;
    logic [31:0] sampleReg = '0;
    logic [7:0]  seq = '0;
    int          testsRun = 0;
    int          testsFailed = 0;

    sample_sequencer_if #(.DATA_W(32), .ENTRY_W(EW), .LEVEL_W(7)) bus ();

    sample_sequencer #(
        .NUM_CHANNELS (16),
        .CH_BASE      (0),
        .DATA_W       (32),
        .DEPTH        (64),
        .CFG_BASE     (19'h300)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.current_time = timeNow;
    assign bus.sample_data  = sampleReg;

    // Channel model: the selected channel presents its sample in the cycle after the request.
    always @(posedge clk) begin
        timeNow <= timeNow + 32'd1;
        if (bus.output_sample) begin
            sampleReg <= {16'hDA7A, bus.channel_select, seq};
            seq <= seq + 8'd1;
        end
    end

    task automatic cmdWrite(input logic [18:0] offs, input logic [31:0] data);
        @(negedge clk);
        bus.cmd_en = 1'b1; bus.cmd_wr = 1'b1;
        bus.cmd_addr = 19'h300 + offs; bus.cmd_data = data;
        @(negedge clk);
        bus.cmd_en = 1'b0; bus.cmd_wr = 1'b0;
    endtask

    task automatic waitSelect(input int maxCycles, output logic found);
        found = 1'b0;
        for (int i = 0; i < maxCycles && !found; i++) begin
            @(negedge clk);
            if (bus.output_sample) found = 1'b1;
        end
    endtask

    task automatic test_reset;
        testsRun += 7;
        if (bus.output_sample !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_os: got %b, want 0", bus.output_sample); end
        if (bus.channel_select !== 8'h00) begin testsFailed++; $display("[TB] FAIL reset_ch: got %h, want 00", bus.channel_select); end
        if (bus.empty !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_empty: got %b, want 1", bus.empty); end
        if (bus.level !== 7'd0) begin testsFailed++; $display("[TB] FAIL reset_level: got %0d, want 0", bus.level); end
        if (bus.overflow_cnt !== 16'd0) begin testsFailed++; $display("[TB] FAIL reset_ovf: got %0d, want 0", bus.overflow_cnt); end
        if (bus.overrun !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_overrun: got %b, want 0", bus.overrun); end
        if (bus.rd_data !== '0) begin testsFailed++; $display("[TB] FAIL reset_rd_data: got %h, want 0", bus.rd_data); end
    endtask

    task automatic test_scan;
        logic [31:0] tsLog [4];
        int          nSel;
        logic        expOs;
        logic [7:0]  expCh;
        logic [39:0] expEntry;
        cmdWrite(DIV, 32'd9);
        cmdWrite(MASK, 32'h5);
        cmdWrite(CTRL, 32'h1);
        nSel = 0;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            expOs = (k == 10) || (k == 12) || (k == 20) || (k == 22);
            testsRun++;
            if (bus.output_sample !== expOs) begin testsFailed++; $display("[TB] FAIL scan_os[%0d]: got %b, want %b", k, bus.output_sample, expOs); end
            if (expOs) begin
                expCh = ((k == 12) || (k == 22)) ? 8'd2 : 8'd0;
                testsRun++;
                if (bus.channel_select !== expCh) begin testsFailed++; $display("[TB] FAIL scan_ch[%0d]: got %h, want %h", k, bus.channel_select, expCh); end
                if (nSel < 4) tsLog[nSel] = timeNow;
                nSel++;
            end
        end
        cmdWrite(CTRL, 32'h0);
        testsRun++;
        if (bus.level !== 7'd4) begin testsFailed++; $display("[TB] FAIL scan_level: got %0d, want 4", bus.level); end
        for (int i = 0; i < 4; i++) begin
            expCh = (i % 2 == 1) ? 8'd2 : 8'd0;
            expEntry = {expCh, 16'hDA7A, expCh, 8'(i)};
            testsRun++;
            if (bus.rd_data[39:0] !== expEntry) begin testsFailed++; $display("[TB] FAIL scan_entry[%0d]: got %h, want %h", i, bus.rd_data[39:0], expEntry); end
`ifdef TIMESTAMP_EN
            testsRun++;
            if (bus.rd_data[EW-1 -: 32] !== tsLog[i]) begin testsFailed++; $display("[TB] FAIL scan_ts[%0d]: got %h, want %h", i, bus.rd_data[EW-1 -: 32], tsLog[i]); end
`endif
            bus.rd_en = 1'b1;
            @(negedge clk);
            bus.rd_en = 1'b0;
        end
        testsRun++;
        if (bus.empty !== 1'b1) begin testsFailed++; $display("[TB] FAIL scan_drained: got %b, want 1", bus.empty); end
    endtask

    task automatic test_overflow;
        logic found;
        logic [39:0] expEntry;
        cmdWrite(DIV, 32'd3);
        cmdWrite(MASK, 32'h1);
        cmdWrite(CTRL, 32'h1);
        for (int n = 0; n < 70; n++) begin
            waitSelect(20, found);
            if (!found) begin
                testsRun++; testsFailed++;
                $display("[TB] FAIL ovf_tick[%0d]: got no select, want select", n);
                break;
            end
        end
        cmdWrite(CTRL, 32'h0);
        repeat (2) @(negedge clk);
        expEntry = {8'd0, 16'hDA7A, 8'd0, 8'd4};
        testsRun += 3;
        if (bus.level !== 7'd64) begin testsFailed++; $display("[TB] FAIL ovf_level: got %0d, want 64", bus.level); end
        if (bus.overflow_cnt !== 16'd6) begin testsFailed++; $display("[TB] FAIL ovf_cnt: got %0d, want 6", bus.overflow_cnt); end
        if (bus.rd_data[39:0] !== expEntry) begin testsFailed++; $display("[TB] FAIL ovf_head: got %h, want %h", bus.rd_data[39:0], expEntry); end
    endtask

    task automatic test_back_to_back;
        logic found;
        logic [7:0] expSeq;
        logic [39:0] expEntry;
        cmdWrite(CTRL, 32'h1);
        waitSelect(20, found);
        testsRun++;
        if (found !== 1'b1) begin testsFailed++; $display("[TB] FAIL b2b_select: got %b, want 1", found); end
        @(negedge clk);
        bus.rd_en = 1'b1;
        bus.cmd_en = 1'b1; bus.cmd_wr = 1'b1; bus.cmd_addr = 19'h300 + CTRL; bus.cmd_data = 32'h0;
        @(negedge clk);
        bus.rd_en = 1'b0; bus.cmd_en = 1'b0; bus.cmd_wr = 1'b0;
        testsRun += 2;
        if (bus.level !== 7'd64) begin testsFailed++; $display("[TB] FAIL b2b_level: got %0d, want 64", bus.level); end
        if (bus.overflow_cnt !== 16'd6) begin testsFailed++; $display("[TB] FAIL b2b_ovf: got %0d, want 6", bus.overflow_cnt); end
        for (int i = 0; i < 64; i++) begin
            expSeq = (i < 63) ? 8'(5 + i) : 8'd74;
            expEntry = {8'd0, 16'hDA7A, 8'd0, expSeq};
            testsRun++;
            if (bus.rd_data[39:0] !== expEntry) begin testsFailed++; $display("[TB] FAIL b2b_entry[%0d]: got %h, want %h", i, bus.rd_data[39:0], expEntry); end
            bus.rd_en = 1'b1;
            @(negedge clk);
            bus.rd_en = 1'b0;
        end
        testsRun++;
        if (bus.empty !== 1'b1) begin testsFailed++; $display("[TB] FAIL b2b_drained: got %b, want 1", bus.empty); end
    endtask

    task automatic test_overrun_clear;
        logic found;
        cmdWrite(DIV, 32'd10);
        cmdWrite(MASK, 32'hFFFF);
        cmdWrite(CTRL, 32'h1);
        waitSelect(30, found);
        testsRun += 3;
        if (found !== 1'b1) begin testsFailed++; $display("[TB] FAIL orun_select: got %b, want 1", found); end
        if (bus.channel_select !== 8'd0) begin testsFailed++; $display("[TB] FAIL orun_first_ch: got %h, want 00", bus.channel_select); end
        if (bus.overrun !== 1'b0) begin testsFailed++; $display("[TB] FAIL orun_early: got %b, want 0", bus.overrun); end
        for (int j = 1; j < 16; j++) begin
            repeat (2) @(negedge clk);
            testsRun += 2;
            if (bus.output_sample !== 1'b1) begin testsFailed++; $display("[TB] FAIL orun_os[%0d]: got %b, want 1", j, bus.output_sample); end
            if (bus.channel_select !== 8'(j)) begin testsFailed++; $display("[TB] FAIL orun_ch[%0d]: got %h, want %h", j, bus.channel_select, 8'(j)); end
            if (j == 5) begin
                testsRun++;
                if (bus.overrun !== 1'b0) begin testsFailed++; $display("[TB] FAIL orun_before_tick2: got %b, want 0", bus.overrun); end
            end
        end
        testsRun++;
        if (bus.overrun !== 1'b1) begin testsFailed++; $display("[TB] FAIL orun_set: got %b, want 1", bus.overrun); end
        cmdWrite(CTRL, 32'h0);
        repeat (2) @(negedge clk);
        testsRun += 2;
        if (bus.level !== 7'd16) begin testsFailed++; $display("[TB] FAIL orun_level: got %0d, want 16", bus.level); end
        if (bus.overflow_cnt !== 16'd6) begin testsFailed++; $display("[TB] FAIL pre_clear_ovf: got %0d, want 6", bus.overflow_cnt); end
        cmdWrite(CTRL, 32'h2);
        testsRun += 4;
        if (bus.level !== 7'd0) begin testsFailed++; $display("[TB] FAIL clear_level: got %0d, want 0", bus.level); end
        if (bus.empty !== 1'b1) begin testsFailed++; $display("[TB] FAIL clear_empty: got %b, want 1", bus.empty); end
        if (bus.overflow_cnt !== 16'd0) begin testsFailed++; $display("[TB] FAIL clear_ovf: got %0d, want 0", bus.overflow_cnt); end
        if (bus.overrun !== 1'b0) begin testsFailed++; $display("[TB] FAIL clear_overrun: got %b, want 0", bus.overrun); end
    endtask

    task automatic test_reset_mid_capture;
        logic found;
        logic sawSelect;
        cmdWrite(DIV, 32'd3);
        cmdWrite(MASK, 32'h1);
        cmdWrite(CTRL, 32'h1);
        waitSelect(20, found);
        waitSelect(20, found);
        testsRun += 2;
        if (found !== 1'b1) begin testsFailed++; $display("[TB] FAIL rst_select: got %b, want 1", found); end
        if (bus.level !== 7'd1) begin testsFailed++; $display("[TB] FAIL rst_pre_level: got %0d, want 1", bus.level); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        testsRun += 4;
        if (bus.output_sample !== 1'b0) begin testsFailed++; $display("[TB] FAIL rst_os: got %b, want 0", bus.output_sample); end
        if (bus.empty !== 1'b1) begin testsFailed++; $display("[TB] FAIL rst_empty: got %b, want 1", bus.empty); end
        if (bus.level !== 7'd0) begin testsFailed++; $display("[TB] FAIL rst_level: got %0d, want 0", bus.level); end
        if (bus.rd_data !== '0) begin testsFailed++; $display("[TB] FAIL rst_rd_data: got %h, want 0", bus.rd_data); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sawSelect = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.output_sample) sawSelect = 1'b1;
        end
        testsRun++;
        if (sawSelect !== 1'b0) begin testsFailed++; $display("[TB] FAIL rst_run_cleared: got %b, want 0", sawSelect); end
    endtask

    initial begin
        bus.cmd_en = 1'b0; bus.cmd_wr = 1'b0; bus.cmd_addr = '0; bus.cmd_data = '0;
        bus.rd_en = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        test_reset;
        rst_n = 1'b1;
        @(negedge clk);
        test_scan;
        test_overflow;
        test_back_to_back;
        test_overrun_clear;
        test_reset_mid_capture;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
